// File: rtl/core_bus_ram.sv
// ----------------------------------------------------------------------------
// core_bus_ram
//   Word-addressed on-chip RAM that answers core bus requests after a fixed
//   number of wait states. It decodes its own address window. It raises a
//   sticky fault when a request falls outside that window, and also when a
//   new request arrives while one is still waiting.
//
// Parameters
//   DEPTH   : number of 32-bit words (power of two, 2..65536)
//   BASE    : word address of entry 0 (aligned to DEPTH)
//   LATENCY : cycles from the accepting edge to the bus_ready pulse (1..15)
//
// Ports
//   clk         in   core clock, all state on posedge
//   rst         in   asynchronous active-high reset
//   bus_start   in   request valid this cycle
//   bus_write   in   1 = write, 0 = read
//   bus_addr    in   30-bit word address
//   bus_data_wr in   write data
//   bus_data_be in   byte enables, bit i covers byte [8i+7:8i]
//   bus_ready   out  one-cycle completion pulse
//   bus_data_rd out  read data, non-zero only in a read's ready cycle
//   fault       out  sticky error flag
//   fault_clr   in   synchronous clear of fault (a same-edge set wins)
// ----------------------------------------------------------------------------
module core_bus_ram #(
   parameter int          DEPTH   = 1024,
   parameter logic [29:0] BASE    = 30'h0,
   parameter int          LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_start,
   input  logic        bus_write,
   input  logic [29:0] bus_addr,
   input  logic [31:0] bus_data_wr,
   input  logic [3:0]  bus_data_be,
   output logic        bus_ready,
   output logic [31:0] bus_data_rd,
   output logic        fault,
   input  logic        fault_clr
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
   // The window bounds are one bit wider so BASE+DEPTH cannot wrap.
   localparam logic [30:0] WIN_LO   = {1'b0, BASE};
   localparam logic [30:0] WIN_HI   = {1'b0, BASE} + 31'(DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            write_q, write_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      be_q, be_d;
   logic            in_win_q, in_win_d;
   logic            fault_q, fault_d;

   logic [31:0]     mem [DEPTH];

   logic            ready;
   logic            accept;
   logic            violation;
   logic            commit;
   logic            addr_in_win;

   // Request decode: window check, completion, acceptance and protocol abuse.
   always_comb begin
      addr_in_win = ({1'b0, bus_addr} >= WIN_LO) && ({1'b0, bus_addr} < WIN_HI);
      ready       = (state_q == ST_WAIT) && (cnt_q == 4'd0);
      // A new start is taken when idle, or in the completion cycle of the
      // current request so that back-to-back traffic has no dead cycle.
      accept      = bus_start && ((state_q == ST_IDLE) || ready);
      violation   = bus_start && (state_q == ST_WAIT) && !ready;
      commit      = ready && write_q && in_win_q;
   end

   // Next-state, counter, request latch and sticky fault.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (ready) begin
               if (accept) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept) begin
         cnt_d = CNT_LOAD;
      end else begin
         cnt_d = cnt_d;
      end

      // BASE is aligned to DEPTH, so addr - BASE only differs from addr in
      // bits above the index; the low bits are the index directly.
      write_d  = accept ? bus_write         : write_q;
      idx_d    = accept ? bus_addr[AW-1:0]  : idx_q;
      wdata_d  = accept ? bus_data_wr       : wdata_q;
      be_d     = accept ? bus_data_be       : be_q;
      in_win_d = accept ? addr_in_win       : in_win_q;

      if (violation || (ready && !in_win_q)) begin
         fault_d = 1'b1;
      end else if (fault_clr) begin
         fault_d = 1'b0;
      end else begin
         fault_d = fault_q;
      end
   end

   // Control and request registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         write_q  <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= 32'h0;
         be_q     <= 4'h0;
         in_win_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         in_win_q <= in_win_d;
         fault_q  <= fault_d;
      end
   end

   // Storage array: byte-masked write on the completion edge, no reset.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
               mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   // A read accepted on a write's completion edge sees the committed word,
   // since the array is looked up with the registered index in the ready cycle.
   always_comb begin
      bus_ready = ready;
      if (ready && !write_q && in_win_q) begin
         bus_data_rd = mem[idx_q];
      end else begin
         bus_data_rd = 32'h0;
      end
      fault = fault_q;
   end

endmodule

// File: tb/tb_core_bus_ram.sv
// ----------------------------------------------------------------------------
// tb_core_bus_ram
//   Three core_bus_ram builds share one request stream:
//     dut0: DEPTH 1024, BASE 0,      LATENCY 2
//     dut1: DEPTH 16,   BASE 0,      LATENCY 1
//     dut2: DEPTH 1024, BASE 30'h100, LATENCY 3
//   A time-stamped transaction model predicts ready/data/fault for every
//   build every cycle; directed sequences add literal expectations.
// ----------------------------------------------------------------------------
module tb_core_bus_ram;

   localparam int          LAT [3] = '{2, 1, 3};
   localparam int          DEP [3] = '{1024, 16, 1024};
   localparam logic [29:0] BAS [3] = '{30'h0, 30'h0, 30'h100};

   logic        clk;
   logic        rst;
   logic        bus_start;
   logic        bus_write;
   logic [29:0] bus_addr;
   logic [31:0] bus_data_wr;
   logic [3:0]  bus_data_be;
   logic        fault_clr;

   logic [2:0]        rdy_v;
   logic [2:0]        flt_v;
   logic [2:0][31:0]  rd_v;

   int n_vec = 0;
   int n_mis = 0;

   core_bus_ram #(.DEPTH(1024), .BASE(30'h0), .LATENCY(2)) dut0 (
      .clk(clk), .rst(rst), .bus_start(bus_start), .bus_write(bus_write),
      .bus_addr(bus_addr), .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be),
      .bus_ready(rdy_v[0]), .bus_data_rd(rd_v[0]), .fault(flt_v[0]), .fault_clr(fault_clr));

   core_bus_ram #(.DEPTH(16), .BASE(30'h0), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .bus_start(bus_start), .bus_write(bus_write),
      .bus_addr(bus_addr), .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be),
      .bus_ready(rdy_v[1]), .bus_data_rd(rd_v[1]), .fault(flt_v[1]), .fault_clr(fault_clr));

   core_bus_ram #(.DEPTH(1024), .BASE(30'h100), .LATENCY(3)) dut2 (
      .clk(clk), .rst(rst), .bus_start(bus_start), .bus_write(bus_write),
      .bus_addr(bus_addr), .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be),
      .bus_ready(rdy_v[2]), .bus_data_rd(rd_v[2]), .fault(flt_v[2]), .fault_clr(fault_clr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s dut%0d: got %h want %h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each build holds at most one request; it completes at a known cycle
   // number (accept cycle + LATENCY). Memory bytes are tracked as known or
   // unknown because the RAM is not cleared.
   int          cyc = 0;
   bit          pend   [3];
   int          done_t [3];
   bit          p_wr   [3];
   bit          p_in   [3];
   int          p_off  [3];
   logic [31:0] p_d    [3];
   logic [3:0]  p_be   [3];
   bit          flt_m  [3];
   logic [31:0] mem_m  [3][1024];
   logic [3:0]  kn_m   [3][1024];

   bit          e_rdy;
   bit          set_f;
   logic [31:0] e_rd;
   logic [31:0] msk;

   function automatic bit in_win(input int k, input logic [29:0] a);
      longint lo;
      lo = longint'(BAS[k]);
      return (longint'(a) >= lo) && (longint'(a) < lo + longint'(DEP[k]));
   endfunction

   initial begin
      for (int k = 0; k < 3; k++) begin
         pend[k]  = 1'b0;
         flt_m[k] = 1'b0;
         for (int i = 0; i < 1024; i++) kn_m[k][i] = 4'h0;
      end
   end

   // Compare every build against the model on each falling edge, then
   // advance the model across the coming rising edge.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            pend[k]  = 1'b0;
            flt_m[k] = 1'b0;
            chk("rst_ready", k, {31'b0, rdy_v[k]}, 32'h0);
            chk("rst_rdata", k, rd_v[k], 32'h0);
            chk("rst_fault", k, {31'b0, flt_v[k]}, 32'h0);
         end else begin
            e_rdy = pend[k] && (cyc == done_t[k]);
            e_rd  = 32'h0;
            msk   = 32'hFFFF_FFFF;
            if (e_rdy && !p_wr[k] && p_in[k]) begin
               e_rd = mem_m[k][p_off[k]];
               for (int b = 0; b < 4; b++)
                  msk[8*b +: 8] = kn_m[k][p_off[k]][b] ? 8'hFF : 8'h00;
            end
            chk("ready", k, {31'b0, rdy_v[k]}, {31'b0, e_rdy});
            if (msk != 32'h0) chk("rdata", k, rd_v[k] & msk, e_rd & msk);
            chk("fault", k, {31'b0, flt_v[k]}, {31'b0, flt_m[k]});

            set_f = 1'b0;
            if (e_rdy) begin
               if (!p_in[k]) begin
                  set_f = 1'b1;
               end else if (p_wr[k]) begin
                  for (int b = 0; b < 4; b++) begin
                     if (p_be[k][b]) begin
                        mem_m[k][p_off[k]][8*b +: 8] = p_d[k][8*b +: 8];
                        kn_m[k][p_off[k]][b] = 1'b1;
                     end
                  end
               end
               pend[k] = 1'b0;
            end
            if (bus_start) begin
               if (pend[k]) begin
                  set_f = 1'b1;
               end else begin
                  pend[k]   = 1'b1;
                  done_t[k] = cyc + LAT[k];
                  p_wr[k]   = bus_write;
                  p_in[k]   = in_win(k, bus_addr);
                  p_off[k]  = p_in[k] ? int'(bus_addr - BAS[k]) : 0;
                  p_d[k]    = bus_data_wr;
                  p_be[k]   = bus_data_be;
               end
            end
            if (set_f) flt_m[k] = 1'b1;
            else if (fault_clr) flt_m[k] = 1'b0;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus_start = 1'b0;
      repeat (n) step();
   endtask

   task automatic req(input logic w, input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
      bus_start   = 1'b1;
      bus_write   = w;
      bus_addr    = a;
      bus_data_wr = d;
      bus_data_be = be;
      step();
      bus_start   = 1'b0;
   endtask

   task automatic clear_fault();
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
   endtask

   // One isolated transaction with literal expectations on build k.
   task automatic pin(input int k, input logic w, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_f);
      req(w, a, d, be);
      for (int i = 1; i < LAT[k]; i++) begin
         @(negedge clk);
         chk("pin_early", k, {31'b0, rdy_v[k]}, 32'h0);
         step();
      end
      @(negedge clk);
      chk("pin_ready", k, {31'b0, rdy_v[k]}, 32'h1);
      chk("pin_rdata", k, rd_v[k], exp_rd);
      step();
      @(negedge clk);
      chk("pin_single", k, {31'b0, rdy_v[k]}, 32'h0);
      chk("pin_fault", k, {31'b0, flt_v[k]}, {31'b0, exp_f});
      idle(3);
   endtask

   function automatic logic [29:0] pick_addr(input int r);
      if (r < 8)       return 30'(r);
      else if (r < 16) return 30'h100 + 30'(r - 8);
      else if (r == 16) return 30'h0FF;
      else if (r == 17) return 30'h500;
      else             return 30'h3FFF_FFFF;
   endfunction

   initial begin
      rst = 1'b1; bus_start = 1'b0; bus_write = 1'b0; bus_addr = 30'h0;
      bus_data_wr = 32'h0; bus_data_be = 4'h0; fault_clr = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      idle(2);

      // basic write then read
      pin(0, 1'b1, 30'd5, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
      pin(0, 1'b0, 30'd5, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

      // byte enables
      pin(0, 1'b1, 30'd6, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
      pin(0, 1'b1, 30'd6, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
      pin(0, 1'b0, 30'd6, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
      pin(0, 1'b1, 30'd6, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
      pin(0, 1'b0, 30'd6, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);

      // out of window on the BASE=0x100 build
      clear_fault();
      pin(2, 1'b1, 30'h100, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
      pin(2, 1'b0, 30'h0FF, 32'h0, 4'h0, 32'h0, 1'b1);
      clear_fault();
      @(negedge clk);
      chk("clr_fault", 2, {31'b0, flt_v[2]}, 32'h0);
      step();
      pin(2, 1'b1, 30'h500, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
      pin(2, 1'b0, 30'h100, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
      clear_fault();

      // back-to-back on dut0: one start every 2 cycles lands in each ready cycle
      for (int i = 0; i < 16; i++) begin
         bus_start   = 1'b1;
         bus_write   = (i % 2 == 0);
         bus_addr    = 30'((i / 2) % 4);
         bus_data_wr = $urandom;
         bus_data_be = 4'hF;
         @(negedge clk);
         if (i > 0) chk("b2b_ready", 0, {31'b0, rdy_v[0]}, 32'h1);
         step();
         bus_start = 1'b0;
         @(negedge clk);
         chk("b2b_gap", 0, {31'b0, rdy_v[0]}, 32'h0);
         step();
      end
      @(negedge clk);
      chk("b2b_last", 0, {31'b0, rdy_v[0]}, 32'h1);
      idle(4);

      // continuous starts on the LATENCY=1 build
      for (int i = 0; i < 8; i++) begin
         bus_start   = 1'b1;
         bus_write   = (i % 2 == 0);
         bus_addr    = 30'(8 + i / 2);
         bus_data_wr = $urandom;
         bus_data_be = 4'hF;
         @(negedge clk);
         if (i > 0) chk("cont_ready", 1, {31'b0, rdy_v[1]}, 32'h1);
         step();
      end
      bus_start = 1'b0;
      @(negedge clk);
      chk("cont_last", 1, {31'b0, rdy_v[1]}, 32'h1);
      idle(4);

      // protocol violation on dut0
      clear_fault();
      req(1'b0, 30'd5, 32'h0, 4'h0);
      bus_start = 1'b1; bus_write = 1'b1; bus_addr = 30'd5;
      bus_data_wr = 32'h0; bus_data_be = 4'hF;
      @(negedge clk);
      chk("viol_wait", 0, {31'b0, rdy_v[0]}, 32'h0);
      step();
      bus_start = 1'b0;
      @(negedge clk);
      chk("viol_ready", 0, {31'b0, rdy_v[0]}, 32'h1);
      chk("viol_rdata", 0, rd_v[0], 32'hDEAD_BEEF);
      step();
      @(negedge clk);
      chk("viol_single", 0, {31'b0, rdy_v[0]}, 32'h0);
      chk("viol_fault", 0, {31'b0, flt_v[0]}, 32'h1);
      idle(3);
      pin(0, 1'b0, 30'd5, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);

      // reset in the middle of a write
      clear_fault();
      pin(0, 1'b1, 30'd7, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
      req(1'b1, 30'd7, 32'h7777_7777, 4'hF);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid", 0, {31'b0, rdy_v[0]}, 32'h0);
      step();
      step();
      rst = 1'b0;
      idle(2);
      pin(0, 1'b0, 30'd7, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         bus_start   = ($urandom_range(0, 1) == 1);
         bus_write   = ($urandom_range(0, 1) == 1);
         bus_addr    = pick_addr(int'($urandom_range(0, 18)));
         bus_data_wr = $urandom;
         bus_data_be = 4'($urandom_range(0, 15));
         fault_clr   = ($urandom_range(0, 15) == 0);
         step();
      end
      fault_clr = 1'b0;
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
